// File: rtl/ysyx_25060173_lsu_pkg.sv
// rtl/ysyx_25060173_lsu_pkg.sv - shared types and helpers for the load/store unit
// Contents: access size enum, FSM state enum, misalignment check.
package ysyx_25060173_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Only the low three address bits matter for any legal size.
    function automatic logic misaligned(input logic [2:0] addr_lo, input size_e size);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25060173_lsu_align.sv
// rtl/ysyx_25060173_lsu_align.sv - combinational lane steering for loads and stores
// Ports: off/size/is_unsigned select the lanes; mem_rdata -> load_data (extended);
//        st_wdata -> store_wdata (replicated) and store_wstrb (byte enables).
module ysyx_25060173_lsu_align
    import ysyx_25060173_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  off,
    input  size_e             size,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic [XLEN-1:0]   st_wdata,
    output logic [XLEN-1:0]   load_data,
    output logic [XLEN-1:0]   store_wdata,
    output logic [STRB_W-1:0] store_wstrb
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      strb_base;

    always_comb begin
        shifted = mem_rdata >> {off, 3'b000};
        case (size)
            SZ_B:    load_data = is_unsigned ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            SZ_H:    load_data = is_unsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            SZ_W:    load_data = is_unsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: load_data = shifted;
        endcase
    end

    // Replicating the low bits across the word puts the data in every lane;
    // the strobes then pick which lanes the bus actually writes.
    always_comb begin
        case (size)
            SZ_B: begin
                store_wdata = {STRB_W{st_wdata[7:0]}};
                strb_base   = 8'h01;
            end
            SZ_H: begin
                store_wdata = {(XLEN/16){st_wdata[15:0]}};
                strb_base   = 8'h03;
            end
            SZ_W: begin
                store_wdata = {(XLEN/32){st_wdata[31:0]}};
                strb_base   = 8'h0F;
            end
            default: begin
                store_wdata = st_wdata;
                strb_base   = 8'hFF;
            end
        endcase
        store_wstrb = STRB_W'(strb_base) << off;
    end

endmodule

// File: rtl/ysyx_25060173_lsu.sv
// rtl/ysyx_25060173_lsu.sv - multi-cycle load/store unit with valid/ready core and bus sides
// Ports: req_* core request in, resp_* response out, mem_* data bus, busy status.
// Flow: IDLE -> REQ -> WAIT -> RESP -> IDLE; bad requests skip straight to RESP.
module ysyx_25060173_lsu
    import ysyx_25060173_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                busy
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q, state_d;
    logic                we_q;
    size_e               size_q;
    logic                uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     rdata_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept;
    logic                bad_req;
    logic                timeout_hit;
    logic [XLEN-1:0]     load_data;
    logic [XLEN-1:0]     store_wdata;
    logic [STRB_W-1:0]   store_wstrb;

    assign accept      = req_valid && (state_q == ST_IDLE);
    assign bad_req     = misaligned(req_addr[2:0], size_e'(req_size))
                         || (req_size == 2'd3 && XLEN < 64);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    ysyx_25060173_lsu_align #(.XLEN(XLEN)) u_align (
        .off         (addr_q[OFF_W-1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .mem_rdata   (mem_rdata),
        .st_wdata    (wdata_q),
        .load_data   (load_data),
        .store_wdata (store_wdata),
        .store_wstrb (store_wstrb)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = bad_req ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
            // A response arriving on the timeout cycle still counts as a response.
            ST_WAIT: if (mem_resp_valid || timeout_hit) state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    we_q    <= req_we;
                    size_q  <= size_e'(req_size);
                    uns_q   <= req_unsigned;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    err_q   <= bad_req;
                    cnt_q   <= '0;
                end
                ST_REQ: if (mem_req_ready) cnt_q <= '0;
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= we_q ? '0 : load_data;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are zero outside REQ so an idle LSU presents a quiet bus.
    always_comb begin
        req_ready     = (state_q == ST_IDLE);
        busy          = (state_q != ST_IDLE);
        mem_req_valid = (state_q == ST_REQ);
        mem_we        = mem_req_valid && we_q;
        mem_addr      = mem_req_valid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
        mem_wdata     = mem_we ? store_wdata : '0;
        mem_wstrb     = mem_we ? store_wstrb : '0;
        resp_valid    = (state_q == ST_RESP);
        resp_rdata    = resp_valid ? rdata_q : '0;
        resp_err      = resp_valid && err_q;
    end

endmodule
